// File: rtl/flag_register.sv
// Condition-flag register (Z/N/C/P) with save/restore and a synchronized,
// edge-detected, maskable interrupt-pending latch feeding the jump selector.
module flag_register #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_carry,
  input  logic             flags_we,
  input  logic             flags_restore,
  input  logic [3:0]       flags_in,
  input  logic             irq,
  input  logic             ie_set,
  input  logic             ie_clr,
  input  logic             int_ack,
  output logic             Z,
  output logic             N,
  output logic             C,
  output logic             P,
  output logic             intp,
  output logic [3:0]       flags_out
);

  logic s1, s2, s3;
  logic rise_det;
  logic pending;
  logic ie;
  logic [3:0] flags_nxt;

  // Packs {P,C,N,Z} from an ALU result; P is 1 for even parity.
  function automatic logic [3:0] calc_flags(input logic [WIDTH-1:0] res,
                                            input logic carry);
    calc_flags = {~^res, carry, res[WIDTH-1], ~|res};
  endfunction

  always_comb begin
    flags_nxt = {P, C, N, Z};
    if (flags_restore)
      flags_nxt = flags_in;
    else if (flags_we)
      flags_nxt = calc_flags(alu_result, alu_carry);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      {P, C, N, Z} <= 4'b0000;
    else
      {P, C, N, Z} <= flags_nxt;
  end

  // irq crosses into clk domain here; s3 holds the previous synchronized level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= irq;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_det = s2 & ~s3;

  // A new edge outranks an acknowledge so a request arriving during ack is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pending <= 1'b0;
    else if (rise_det)
      pending <= 1'b1;
    else if (int_ack)
      pending <= 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      ie <= 1'b0;
    else if (int_ack || ie_clr)
      ie <= 1'b0;
    else if (ie_set)
      ie <= 1'b1;
  end

  assign intp      = pending & ie;
  assign flags_out = {P, C, N, Z};

endmodule

// File: tb/tb_flag_register.sv
// Randomized and directed self-checking bench for flag_register against a
// sample-history reference model of the flag and interrupt rules.
module tb_flag_register;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] alu_result;
  logic             alu_carry;
  logic             flags_we;
  logic             flags_restore;
  logic [3:0]       flags_in;
  logic             irq;
  logic             ie_set;
  logic             ie_clr;
  logic             int_ack;
  logic             Z, N, C, P, intp;
  logic [3:0]       flags_out;

  int checks = 0;
  int passes = 0;

  // Reference model state
  logic [3:0] mflags;
  logic       mpend;
  logic       mie;
  logic       hist[$];

  flag_register #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset(reset), .alu_result(alu_result), .alu_carry(alu_carry),
    .flags_we(flags_we), .flags_restore(flags_restore), .flags_in(flags_in),
    .irq(irq), .ie_set(ie_set), .ie_clr(ie_clr), .int_ack(int_ack),
    .Z(Z), .N(N), .C(C), .P(P), .intp(intp), .flags_out(flags_out)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    mflags = 4'b0000;
    mpend  = 1'b0;
    mie    = 1'b0;
    hist   = {1'b0, 1'b0, 1'b0};
  endtask

  // One rising edge: inputs are stable, so the model's next state is computed
  // from them; hist[0] is irq seen at the previous edge, hist[1] two edges ago.
  task automatic tick();
    logic [3:0] nf;
    logic       np, ni, rise;
    nf = mflags;
    if (flags_restore)
      nf = flags_in;
    else if (flags_we)
      nf = {($countones(alu_result) % 2 == 0) ? 1'b1 : 1'b0, alu_carry,
            (alu_result >= 8'h80) ? 1'b1 : 1'b0,
            (alu_result == 0) ? 1'b1 : 1'b0};
    rise = hist[1] && !hist[2];
    np = rise ? 1'b1 : (int_ack ? 1'b0 : mpend);
    ni = (int_ack || ie_clr) ? 1'b0 : (ie_set ? 1'b1 : mie);
    @(posedge clk);
    mflags = nf;
    mpend  = np;
    mie    = ni;
    hist.push_front(irq);
    void'(hist.pop_back());
    #1;
  endtask

  task automatic idle_inputs();
    alu_result = '0; alu_carry = 0; flags_we = 0; flags_restore = 0;
    flags_in = 4'b0000; ie_set = 0; ie_clr = 0; int_ack = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    irq = 0;
    reset = 1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({intp, flags_out, Z, N, C, P} !== 9'b0)
      $display("FAIL reset_state: got %b required %b", {intp, flags_out, Z, N, C, P}, 9'b0);
    else passes++;
    @(negedge clk);
    reset = 0;
    tick();
    checks++;
    if ({intp, flags_out} !== 5'b0)
      $display("FAIL reset_release: got %b required %b", {intp, flags_out}, 5'b0);
    else passes++;
  endtask

  task automatic test_flag_capture();
    flags_we = 1; alu_result = 8'h00; alu_carry = 1;
    tick();
    checks++;
    if ({Z, N, C, P} !== 4'b1011)
      $display("FAIL capture_zero: got ZNCP=%b required %b", {Z, N, C, P}, 4'b1011);
    else passes++;
    alu_result = 8'h83; alu_carry = 0;
    tick();
    checks++;
    if ({Z, N, C, P} !== 4'b0100)
      $display("FAIL capture_neg: got ZNCP=%b required %b", {Z, N, C, P}, 4'b0100);
    else passes++;
    flags_we = 0; alu_result = 8'h00; alu_carry = 1;
    tick();
    checks++;
    if ({Z, N, C, P} !== 4'b0100)
      $display("FAIL flag_hold: got ZNCP=%b required %b", {Z, N, C, P}, 4'b0100);
    else passes++;
  endtask

  task automatic test_restore();
    flags_we = 1; flags_restore = 1; flags_in = 4'b1010; alu_result = 8'h00;
    tick();
    idle_inputs();
    checks++;
    if ({P, C, N, Z} !== 4'b1010 || flags_out !== 4'b1010)
      $display("FAIL restore_priority: got PCNZ=%b flags_out=%b required %b",
               {P, C, N, Z}, flags_out, 4'b1010);
    else passes++;
  endtask

  task automatic test_enabled_irq();
    int edges = 0;
    ie_set = 1; tick(); ie_set = 0;
    checks++;
    if (intp !== 1'b0) $display("FAIL irq_idle: got intp=%b required 0", intp);
    else passes++;
    irq = 1;
    while (edges < 8 && intp !== 1'b1) begin
      tick();
      edges++;
    end
    checks++;
    if (edges != 3 || intp !== 1'b1)
      $display("FAIL irq_latency: got %0d edges intp=%b required 3 edges intp=1", edges, intp);
    else passes++;
    int_ack = 1; tick(); int_ack = 0;
    checks++;
    if (intp !== 1'b0) $display("FAIL irq_ack: got intp=%b required 0", intp);
    else passes++;
    repeat (4) tick();
    ie_set = 1; tick(); ie_set = 0;
    checks++;
    if (intp !== 1'b0) $display("FAIL irq_held_no_repeat: got intp=%b required 0", intp);
    else passes++;
  endtask

  task automatic test_masked_irq();
    ie_clr = 1; irq = 0; tick(); ie_clr = 0;
    repeat (3) tick();
    irq = 1; repeat (3) tick(); irq = 0;
    repeat (3) tick();
    checks++;
    if (intp !== 1'b0) $display("FAIL masked_intp: got intp=%b required 0", intp);
    else passes++;
    ie_set = 1; tick(); ie_set = 0;
    checks++;
    if (intp !== 1'b1) $display("FAIL masked_then_enable: got intp=%b required 1", intp);
    else passes++;
    int_ack = 1; tick(); int_ack = 0;
  endtask

  task automatic test_ack_collision();
    ie_set = 1; irq = 0; repeat (3) tick(); ie_set = 0;
    irq = 1; repeat (3) tick();
    irq = 0; repeat (3) tick();
    checks++;
    if (intp !== 1'b1) $display("FAIL collision_setup: got intp=%b required 1", intp);
    else passes++;
    irq = 1; tick(); tick();
    int_ack = 1; tick(); int_ack = 0;
    checks++;
    if (intp !== 1'b0) $display("FAIL collision_ack: got intp=%b required 0", intp);
    else passes++;
    ie_set = 1; tick(); ie_set = 0;
    checks++;
    if (intp !== 1'b1) $display("FAIL collision_kept: got intp=%b required 1", intp);
    else passes++;
    int_ack = 1; ie_set = 1; tick(); int_ack = 0; ie_set = 0;
    checks++;
    if (intp !== 1'b0) $display("FAIL ack_beats_set: got intp=%b required 0", intp);
    else passes++;
    irq = 0; repeat (3) tick();
  endtask

  task automatic test_random();
    int bad = 0;
    for (int i = 0; i < 400; i++) begin
      alu_result    = WIDTH'($urandom);
      alu_carry     = 1'($urandom);
      flags_we      = ($urandom_range(1) == 0);
      flags_restore = ($urandom_range(7) == 0);
      flags_in      = 4'($urandom);
      ie_set        = ($urandom_range(3) == 0);
      ie_clr        = ($urandom_range(7) == 0);
      int_ack       = ($urandom_range(7) == 0);
      if ($urandom_range(3) == 0) irq = ~irq;
      tick();
      checks++;
      if ({P, C, N, Z} !== mflags || flags_out !== mflags || intp !== (mpend & mie)) begin
        if (bad < 10)
          $display("FAIL random_cycle_%0d: got PCNZ=%b flags_out=%b intp=%b required PCNZ=%b intp=%b",
                   i, {P, C, N, Z}, flags_out, intp, mflags, mpend & mie);
        bad++;
      end else passes++;
    end
    idle_inputs();
    irq = 0;
    repeat (3) tick();
  endtask

  task automatic test_async_reset();
    flags_we = 1; alu_result = 8'h00; ie_set = 1; irq = 0;
    tick();
    idle_inputs();
    irq = 1; repeat (3) tick(); irq = 0;
    checks++;
    if (intp !== 1'b1 || Z !== 1'b1)
      $display("FAIL async_setup: got intp=%b Z=%b required 1 1", intp, Z);
    else passes++;
    #2 reset = 1;
    #1;
    checks++;
    if ({intp, flags_out, Z, N, C, P} !== 9'b0)
      $display("FAIL async_reset: got %b required %b", {intp, flags_out, Z, N, C, P}, 9'b0);
    else passes++;
    model_reset();
    @(negedge clk);
    reset = 0;
    repeat (4) tick();
    checks++;
    if ({intp, flags_out} !== 5'b0)
      $display("FAIL after_async_reset: got %b required %b", {intp, flags_out}, 5'b0);
    else passes++;
  endtask

  initial begin
    test_reset();
    test_flag_capture();
    test_restore();
    test_enabled_irq();
    test_masked_irq();
    test_ack_collision();
    test_random();
    test_async_reset();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no completion required completion");
    $fatal(1);
  end

endmodule
